// File: rtl/hv_pair_streamer.sv
// hv_pair_streamer
// Producer end of the HV-memory -> cosine-similarity stream. For every element
// index it reads A[i] and B[i] from a one-cycle-latency memory and presents them
// as a two-beat pair (A tagged first, B tagged last) under valid/ready. After the
// final pair it waits for a rising edge on the consumer's done and captures the
// similarity result.
// Optional feature: define HV_STREAM_ABORT_EN to add an abort input that returns
// the block to idle from any busy state without a complete pulse.
module hv_pair_streamer #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int HV_LENGTH     = 1024,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_a,
  input  logic [ADDR_WIDTH-1:0]    base_b,
  output logic                     mem_rd,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [HV_DATA_WIDTH-1:0] mem_rdata,
  output logic                     valid,
  output logic                     first,
  output logic                     last,
  output logic [HV_DATA_WIDTH-1:0] data_out,
  input  logic                     ready,
  input  logic                     done,
  input  logic [HV_DATA_WIDTH-1:0] result_in,
  output logic [HV_DATA_WIDTH-1:0] result,
  output logic                     busy,
  output logic                     complete
`ifdef HV_STREAM_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  localparam int IDX_W = (HV_LENGTH > 1) ? $clog2(HV_LENGTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HV_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_LOAD_A,
    S_SEND_A,
    S_FETCH_B,
    S_LOAD_B,
    S_SEND_B,
    S_DRAIN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_WIDTH-1:0]   base_a_q;
  logic [ADDR_WIDTH-1:0]   base_b_q;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic                    done_q;
  logic                    abort_hit;
  logic                    xfer;
  logic                    done_rise;
  logic                    idx_last;

`ifdef HV_STREAM_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign xfer      = valid && ready;
  assign done_rise = done && !done_q;
  assign idx_last  = (idx == LAST_IDX);
  assign busy      = (state != S_IDLE);
  assign mem_rd    = (state == S_FETCH_A) || (state == S_FETCH_B);

  // Read address is live during the FETCH states and otherwise holds the last one issued.
  always_comb begin
    mem_addr = addr_hold;
    case (state)
      S_FETCH_A: mem_addr = base_a_q + ADDR_WIDTH'(idx);
      S_FETCH_B: mem_addr = base_b_q + ADDR_WIDTH'(idx);
      default:   mem_addr = addr_hold;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fetch/load/send for A then B, repeat per index, then drain.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_FETCH_A;
      S_FETCH_A: state_next = S_LOAD_A;
      S_LOAD_A:  state_next = S_SEND_A;
      S_SEND_A:  if (xfer) state_next = S_FETCH_B;
      S_FETCH_B: state_next = S_LOAD_B;
      S_LOAD_B:  state_next = S_SEND_B;
      S_SEND_B:  if (xfer) state_next = idx_last ? S_DRAIN : S_FETCH_A;
      S_DRAIN:   if (done_rise) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  // Datapath: base/index capture, beat registers, done edge detect and result capture.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      idx       <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      addr_hold <= '0;
      done_q    <= 1'b0;
      valid     <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      data_out  <= '0;
      result    <= '0;
      complete  <= 1'b0;
    end else begin
      done_q   <= done;
      complete <= 1'b0;
      if (abort_hit) begin
        valid <= 1'b0;
        first <= 1'b0;
        last  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              base_a_q <= base_a;
              base_b_q <= base_b;
              idx      <= '0;
            end
          end
          S_FETCH_A, S_FETCH_B: begin
            addr_hold <= mem_addr;
          end
          S_LOAD_A: begin
            data_out <= mem_rdata;
            valid    <= 1'b1;
            first    <= 1'b1;
            last     <= 1'b0;
          end
          S_SEND_A: begin
            if (xfer) begin
              valid <= 1'b0;
              first <= 1'b0;
            end
          end
          S_LOAD_B: begin
            data_out <= mem_rdata;
            valid    <= 1'b1;
            first    <= 1'b0;
            last     <= 1'b1;
          end
          S_SEND_B: begin
            if (xfer) begin
              valid <= 1'b0;
              last  <= 1'b0;
              if (!idx_last) idx <= idx + IDX_W'(1);
            end
          end
          S_DRAIN: begin
            if (done_rise) begin
              result   <= result_in;
              complete <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hv_pair_streamer.sv
// tb_hv_pair_streamer
// Directed bench for hv_pair_streamer with HV_LENGTH=4 and a memory that
// returns its own address. Cycle c is the interval after clock edge c-1, with
// start sampled at edge 0.
module tb_hv_pair_streamer;

  localparam int DW  = 32;
  localparam int LEN = 4;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic          start;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          valid;
  logic          first;
  logic          last;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          done;
  logic [DW-1:0] result_in;
  logic [DW-1:0] result;
  logic          busy;
  logic          complete;
`ifdef HV_STREAM_ABORT_EN
  logic          abort;
`endif

  int check_count = 0;
  int pass_count  = 0;

  typedef struct packed {
    logic          v;
    logic          f;
    logic          l;
    logic          rd;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } beat_t;

  hv_pair_streamer #(
    .HV_DATA_WIDTH(DW),
    .HV_LENGTH(LEN),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .areset(areset),
    .start(start),
    .base_a(base_a),
    .base_b(base_b),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .valid(valid),
    .first(first),
    .last(last),
    .data_out(data_out),
    .ready(ready),
    .done(done),
    .result_in(result_in),
    .result(result),
    .busy(busy),
    .complete(complete)
`ifdef HV_STREAM_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous read memory: mem[addr] = addr, one cycle latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= DW'(mem_addr);
  end

  // Expected beat/fetch activity in cycle c. Beat k (even = A[k/2], odd = B[k/2])
  // is valid from cycle 3+3k; beat sb is held sl extra cycles, delaying later beats.
  function automatic beat_t model(int c, logic [AW-1:0] ba, logic [AW-1:0] bb, int sb, int sl);
    beat_t         e;
    int            vs;
    int            len;
    logic [AW-1:0] addr;
    e = '0;
    for (int k = 0; k < 2*LEN; k++) begin
      vs   = 3 + 3*k + ((sb >= 0 && k > sb) ? sl : 0);
      len  = (k == sb) ? 1 + sl : 1;
      addr = (((k % 2) == 0) ? ba : bb) + AW'(k / 2);
      if (c >= vs && c < vs + len) begin
        e.v = 1'b1;
        e.f = ((k % 2) == 0);
        e.l = ((k % 2) == 1);
        e.d = DW'(addr);
      end
      if (c == vs - 2) begin
        e.rd = 1'b1;
        e.a  = addr;
      end
    end
    return e;
  endfunction

  // Observed outputs, with data/address masked where the expectation does not care.
  function automatic beat_t observe(beat_t e);
    beat_t o;
    o.v  = valid;
    o.f  = first;
    o.l  = last;
    o.rd = mem_rd;
    o.d  = e.v  ? data_out : '0;
    o.a  = e.rd ? mem_addr : '0;
    return o;
  endfunction

  task automatic test_reset;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_count++;
    if ({valid, first, last, mem_rd, busy, complete, data_out, mem_addr, result} !== '0)
      $display("[TB] FAIL reset_values got v%b f%b l%b rd%b busy%b cpl%b d=%h a=%h r=%h exp all 0",
               valid, first, last, mem_rd, busy, complete, data_out, mem_addr, result);
    else pass_count++;
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    check_count++;
    if ({busy, valid, mem_rd} !== 3'b000)
      $display("[TB] FAIL reset_release_idle got busy%b v%b rd%b exp 000", busy, valid, mem_rd);
    else pass_count++;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    beat_t e, o;
    base_a = 16'h0010; base_b = 16'h0020; ready = 1'b1; done = 1'b0;
    result_in = 32'h3F80_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      done = (c == 30);
      @(negedge clk);
      e = model(c, 16'h0010, 16'h0020, -1, 0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL stream_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      check_count++;
      if ({busy, complete} !== {(c <= 30), (c == 31)})
        $display("[TB] FAIL stream_busy_cpl c=%0d got=%b%b exp=%b%b", c, busy, complete, (c <= 30), (c == 31));
      else pass_count++;
      @(posedge clk); #1;
    end
    check_count++;
    if (result !== 32'h3F80_0000) $display("[TB] FAIL stream_result got=%h exp=3f800000", result);
    else pass_count++;
  endtask

  task automatic test_stall;
    beat_t e, o;
    base_a = 16'h0010; base_b = 16'h0020; ready = 1'b1; done = 1'b0;
    result_in = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      ready = !(c >= 9 && c <= 13);
      done  = (c == 32);
      @(negedge clk);
      e = model(c, 16'h0010, 16'h0020, 2, 5);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL stall_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      check_count++;
      if ({busy, complete} !== {(c <= 32), (c == 33)})
        $display("[TB] FAIL stall_busy_cpl c=%0d got=%b%b exp=%b%b", c, busy, complete, (c <= 32), (c == 33));
      else pass_count++;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    check_count++;
    if (result !== 32'h1111_1111) $display("[TB] FAIL stall_result got=%h exp=11111111", result);
    else pass_count++;
  endtask

  task automatic test_addr_wrap;
    beat_t e, o;
    base_a = 16'hFFFE; base_b = 16'h0020; ready = 1'b1; done = 1'b0;
    result_in = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      done = (c == 30);
      @(negedge clk);
      e = model(c, 16'hFFFE, 16'h0020, -1, 0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL wrap_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      @(posedge clk); #1;
    end
    done = 1'b0;
    check_count++;
    if (result !== 32'h1234_5678) $display("[TB] FAIL wrap_result got=%h exp=12345678", result);
    else pass_count++;
  endtask

  task automatic test_start_ignored;
    beat_t e, o;
    base_a = 16'h0010; base_b = 16'h0020; ready = 1'b1; done = 1'b0;
    result_in = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 39; c++) begin
      start  = (c == 10);
      base_a = (c == 10) ? 16'h0030 : 16'h0010;
      done   = (c != 36);
      @(negedge clk);
      e = model(c, 16'h0010, 16'h0020, -1, 0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL restart_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      check_count++;
      if ({busy, complete} !== {(c <= 37), (c == 38)})
        $display("[TB] FAIL done_edge_cpl c=%0d got=%b%b exp=%b%b", c, busy, complete, (c <= 37), (c == 38));
      else pass_count++;
      @(posedge clk); #1;
    end
    start = 1'b0; done = 1'b0; base_a = 16'h0010;
    check_count++;
    if (result !== 32'h4000_0000) $display("[TB] FAIL done_edge_result got=%h exp=40000000", result);
    else pass_count++;
  endtask

`ifdef HV_STREAM_ABORT_EN
  task automatic test_abort;
    beat_t e, o;
    base_a = 16'h0010; base_b = 16'h0020; ready = 1'b1; done = 1'b0;
    result_in = 32'hDEAD_BEEF; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      abort = (c == 2);
      @(negedge clk);
      e = (c <= 2) ? model(c, 16'h0010, 16'h0020, -1, 0) : beat_t'('0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL abort_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      check_count++;
      if ({busy, complete} !== {(c <= 2), 1'b0})
        $display("[TB] FAIL abort_busy_cpl c=%0d got=%b%b exp=%b0", c, busy, complete, (c <= 2));
      else pass_count++;
      check_count++;
      if (result !== 32'h4000_0000) $display("[TB] FAIL abort_result c=%0d got=%h exp=40000000", c, result);
      else pass_count++;
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_run;
    beat_t e, o;
    base_a = 16'h0010; base_b = 16'h0020; ready = 1'b1; done = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      e = model(c, 16'h0010, 16'h0020, -1, 0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL prereset_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      @(posedge clk); #1;
    end
    check_count++;
    if ({valid, last, data_out} !== {1'b1, 1'b1, 32'h0000_0022})
      $display("[TB] FAIL send_b2_before_reset got v%b l%b d=%h exp v1 l1 d=00000022", valid, last, data_out);
    else pass_count++;
    areset = 1'b1;
    #1;
    check_count++;
    if ({valid, first, last, mem_rd, busy, complete, data_out, mem_addr, result} !== '0)
      $display("[TB] FAIL midrun_reset got v%b f%b l%b rd%b busy%b cpl%b d=%h a=%h r=%h exp all 0",
               valid, first, last, mem_rd, busy, complete, data_out, mem_addr, result);
    else pass_count++;
    @(posedge clk); #1;
    check_count++;
    if ({busy, complete} !== 2'b00) $display("[TB] FAIL reset_no_cpl got=%b%b exp=00", busy, complete);
    else pass_count++;
    areset = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e = model(c, 16'h0010, 16'h0020, -1, 0);
      o = observe(e);
      check_count++;
      if (o !== e) $display("[TB] FAIL rerun_beat c=%0d got=%h exp=%h", c, o, e);
      else pass_count++;
      @(posedge clk); #1;
    end
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; base_a = '0; base_b = '0;
    ready = 1'b0; done = 1'b0; result_in = '0;
`ifdef HV_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_addr_wrap();
    test_start_ignored();
`ifdef HV_STREAM_ABORT_EN
    test_abort();
`endif
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
